// File: rtl/key_fsm_debounce_pkg.sv
// key_fsm_debounce_pkg: shared FSM encodings and default timing for the key front end
package key_fsm_debounce_pkg;
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0001,
    ST_FILTER_DN = 4'b0010,
    ST_DOWN      = 4'b0100,
    ST_FILTER_UP = 4'b1000
  } state_e;
  localparam int KEY_W_DEF     = 4;
  localparam int TIME_20MS_DEF = 1_000_000;
  localparam int TIME_LONG_DEF = 50_000_000;
endpackage

// File: rtl/key_fsm_debounce_filter_ch.sv
// key_filter_ch: one key channel - synchroniser, debounce FSM, hold timer, registered pulses
module key_filter_ch
  import key_fsm_debounce_pkg::*;
#(
  parameter int TIME_20MS = TIME_20MS_DEF,
  parameter int TIME_LONG = TIME_LONG_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_state
);
  localparam int FW = $clog2(TIME_20MS);
  localparam int HW = $clog2(TIME_LONG);
  localparam logic [FW-1:0] FMAX = FW'(TIME_20MS - 1);
  localparam logic [HW-1:0] HMAX = HW'(TIME_LONG - 1);
  logic [1:0] sync_q;
  logic lvl_q;
  state_e st_q, st_d;
  logic [FW-1:0] filt_q, filt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic done_q, done_d;
  logic press_q, press_d, rel_q, rel_d, long_q, long_d, state_q, state_d;
  // lvl_q is a registered copy of the synchroniser output so the FSM enters a filter state on edge 3
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= 2'b11;
      lvl_q   <= 1'b1;
      st_q    <= ST_IDLE;
      filt_q  <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_in};
      lvl_q   <= sync_q[1];
      st_q    <= st_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      state_q <= state_d;
    end
  always_comb begin
    st_d    = st_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    done_d  = done_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    case (st_q)
      ST_IDLE: if (!lvl_q) begin
        st_d   = ST_FILTER_DN;
        filt_d = '0;
      end
      ST_FILTER_DN: if (lvl_q) st_d = ST_IDLE;
      else if (filt_q == FMAX) begin
        st_d    = ST_DOWN;
        press_d = 1'b1;
        hold_d  = '0;
        done_d  = 1'b0;
      end else filt_d = filt_q + 1'b1;
      ST_DOWN: if (lvl_q) begin
        st_d   = ST_FILTER_UP;
        filt_d = '0;
      end
      ST_FILTER_UP: if (!lvl_q) st_d = ST_DOWN;
      else if (filt_q == FMAX) begin
        st_d  = ST_IDLE;
        rel_d = 1'b1;
      end else filt_d = filt_q + 1'b1;
      default: st_d = ST_IDLE;
    endcase
    // done_q limits the long pulse to one per press, even across release bounces
    if (st_q == ST_DOWN || st_q == ST_FILTER_UP) begin
      hold_d = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;
      long_d = (hold_q == HMAX) && !done_q;
      done_d = done_q | long_d;
    end
    state_d = (st_d == ST_DOWN) || (st_d == ST_FILTER_UP);
  end
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign key_long    = long_q;
  assign key_state   = state_q;
endmodule

// File: rtl/key_fsm_debounce.sv
// key_fsm_debounce: KEY_W independent debounced key channels with press/release/long pulses
module key_fsm_debounce
  import key_fsm_debounce_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEF,
  parameter int TIME_20MS = TIME_20MS_DEF,
  parameter int TIME_LONG = TIME_LONG_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long,
  output logic [KEY_W-1:0] key_state
);
  for (genvar i = 0; i < KEY_W; i++) begin : g_ch
    key_filter_ch #(
      .TIME_20MS(TIME_20MS),
      .TIME_LONG(TIME_LONG)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_in     (key_in[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_state  (key_state[i])
    );
  end
endmodule

// File: tb/tb_key_fsm_debounce.sv
// tb_key_fsm_debounce: directed checks of debounce timing, bounce rejection, long press and reset
module tb_key_fsm_debounce;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] key_in = 2'b11;
  logic [1:0] key_press, key_release, key_long, key_state;
  int total = 0;
  int bad = 0;
  int t = 0;
  key_fsm_debounce #(.KEY_W(2), .TIME_20MS(10), .TIME_LONG(40)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d: observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask
  task automatic goto(input int e);
    while (t < e) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic all_zero(input string tag);
    check({tag, "_press"}, key_press, 2'b00);
    check({tag, "_rel"}, key_release, 2'b00);
    check({tag, "_long"}, key_long, 2'b00);
    check({tag, "_state"}, key_state, 2'b00);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    all_zero("idle");
    // clean press on key0, held 100 cycles
    key_in = 2'b10; t = -1;
    for (int e = 0; e < 100; e++) begin
      goto(e);
      check("clean_press", key_press, {1'b0, e == 13});
      check("clean_state", key_state, {1'b0, e >= 13});
      check("clean_long", key_long, {1'b0, e == 53});
      check("clean_rel", key_release, 2'b00);
    end
    // clean release
    key_in = 2'b11; t = -1;
    for (int e = 0; e < 20; e++) begin
      goto(e);
      check("rel_pulse", key_release, {1'b0, e == 13});
      check("rel_state", key_state, {1'b0, e < 13});
      check("rel_press", key_press, 2'b00);
      check("rel_long", key_long, 2'b00);
    end
    // press bounce: low 5, high 3, then low; final falling sample at edge 8
    key_in = 2'b10; t = -1;
    for (int e = 0; e <= 30; e++) begin
      goto(e);
      check("bnc_press", key_press, {1'b0, e == 21});
      check("bnc_state", key_state, {1'b0, e >= 21});
      check("bnc_long", key_long, 2'b00);
      if (e == 4) key_in = 2'b11;
      if (e == 7) key_in = 2'b10;
    end
    // release with a 4-cycle low glitch; last rising sample at edge 7
    key_in = 2'b11; t = -1;
    for (int e = 0; e <= 25; e++) begin
      goto(e);
      check("glt_rel", key_release, {1'b0, e == 20});
      check("glt_state", key_state, {1'b0, e < 20});
      check("glt_press", key_press, 2'b00);
      check("glt_long", key_long, 2'b00);
      if (e == 2) key_in = 2'b10;
      if (e == 6) key_in = 2'b11;
    end
    // short press: 25 low cycles
    key_in = 2'b10; t = -1;
    for (int e = 0; e <= 60; e++) begin
      goto(e);
      check("short_press", key_press, {1'b0, e == 13});
      check("short_rel", key_release, {1'b0, e == 38});
      check("short_state", key_state, {1'b0, e >= 13 && e < 38});
      check("short_long", key_long, 2'b00);
      if (e == 24) key_in = 2'b11;
    end
    // both keys pressed together
    key_in = 2'b00; t = -1;
    for (int e = 0; e <= 15; e++) begin
      goto(e);
      check("sim_press", key_press, (e == 13) ? 2'b11 : 2'b00);
      check("sim_state", key_state, (e >= 13) ? 2'b11 : 2'b00);
      check("sim_rel", key_release, 2'b00);
    end
    // release key1 only
    key_in = 2'b10; t = -1;
    for (int e = 0; e <= 15; e++) begin
      goto(e);
      check("sim1_rel", key_release, (e == 13) ? 2'b10 : 2'b00);
      check("sim1_state", key_state, (e >= 13) ? 2'b01 : 2'b11);
      check("sim1_press", key_press, 2'b00);
      check("sim1_long", key_long, 2'b00);
    end
    // asynchronous reset while key0 is held in DOWN
    #2 rst_n = 1'b0;
    #1 all_zero("rst_async");
    repeat (2) @(negedge clk);
    all_zero("rst_hold");
    rst_n = 1'b1; t = -1;
    for (int e = 0; e <= 15; e++) begin
      goto(e);
      check("rst_press", key_press, {1'b0, e == 13});
      check("rst_state", key_state, {1'b0, e >= 13});
      check("rst_rel", key_release, 2'b00);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/key_fsm_debounce.md
# key_fsm_debounce

Multi-channel push-button front end: it synchronises raw active-low key inputs, debounces each one with a four-state machine, and emits one-cycle press, release and long-press pulses plus a debounced level. It is the input-side counterpart to the timer-driven LED sequencer. It sits between the board key pins and any user-control FSM (mode select, LED pattern step, etc.).

## Interface
- KEY_W, 4, number of independent key channels
- TIME_20MS, 1_000_000, debounce window in clk cycles (20 ms at 50 MHz)
- TIME_LONG, 50_000_000, hold time in clk cycles before long-press fires (1 s at 50 MHz)
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- key_in  input  KEY_W  raw key pins, asynchronous, 0 = pressed
- key_press  output  KEY_W  one-cycle pulse per debounced press
- key_release  output  KEY_W  one-cycle pulse per debounced release
- key_long  output  KEY_W  one-cycle pulse when hold time reaches TIME_LONG
- key_state  output  KEY_W  debounced level, 1 = pressed

## Operation
- Per channel: 2-flop synchroniser, resets to 1 (released).
- One-hot FSM per channel with states IDLE, FILTER_DN, DOWN and FILTER_UP. IDLE is the reset state.
- IDLE: sync==0 → FILTER_DN, clear filter counter.
- FILTER_DN: sync==1 → IDLE (bounce, no output). filt_cnt==TIME_20MS-1 with sync==0 → DOWN, pulse key_press, clear hold counter.
- DOWN: sync==1 → FILTER_UP, clear filter counter.
- FILTER_UP: sync==0 → DOWN (bounce, no output, hold counter not cleared). filt_cnt==TIME_20MS-1 with sync==1 → IDLE, pulse key_release.
- Filter counter: counts +1 each cycle in FILTER_DN/FILTER_UP, cleared on every entry to those states. Width $clog2(TIME_20MS).
- Hold counter: counts in DOWN and FILTER_UP and saturates at TIME_LONG-1. When it reaches TIME_LONG-1, key_long pulses exactly once per press. Width $clog2(TIME_LONG).
- key_state = 1 while in DOWN or FILTER_UP, else 0. It is registered.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Reset values: key_press, key_release, key_long and key_state = 0, all FSMs in IDLE, counters 0.
- Reset mid-operation returns to IDLE with no release pulse. A key still held at reset deassertion is re-debounced and reported as a new press.
- Unreachable one-hot codes → IDLE.

## Timing
- All outputs are registered and update on the same edge as the FSM state.
- Press latency: first clk edge sampling key_in low = edge 0. The synchroniser is full at edge 2, FILTER_DN is entered at edge 3, and key_press/key_state rise at edge TIME_20MS+3.
- Release latency: same arithmetic. key_release pulses and key_state falls at edge TIME_20MS+3 after key_in is first sampled high.
- Long press: key_long pulses TIME_LONG edges after the key_press edge, provided the FSM has not returned to IDLE.
- Any glitch shorter than TIME_20MS cycles (after synchronisation) produces no output.
- Each pulse output is high for exactly 1 cycle.

## Structure
- Shared package: FSM state encodings (IDLE=4'b0001, FILTER_DN=4'b0010, DOWN=4'b0100, FILTER_UP=4'b1000) and the default timing constants.
- Sub-module key_filter_ch: synchroniser, FSM, both counters and outputs for one key. The top level instantiates KEY_W copies with a generate loop and concatenates the outputs.

## Test plan
All scenarios use TIME_20MS=10, TIME_LONG=40, KEY_W=2.
- Clean press: key_in[0] low at edge 0, held 100 cycles → key_press[0] pulse at edge 13, key_state[0]=1 from edge 13, key_long[0] pulse at edge 53 only.
- Press bounce: key_in[0] low for 5 cycles, high for 3, then low → no pulse during the bounce; key_press[0] fires 13 edges after the final falling sample.
- Release: from pressed, key_in[0] high at edge R → key_release[0] pulse and key_state[0]=0 at edge R+13. A 4-cycle low glitch inside the window delays the release and produces no extra press.
- Short press: low for 25 cycles → one press pulse, one release pulse, key_long never asserted.
- Simultaneous: both keys low on the same edge → key_press=2'b11 in the same cycle. Releasing only key1 → key_release=2'b10.
- Reset mid-DOWN: assert rst_n=0 while key0 is held → all outputs 0 immediately, no release pulse. Deassert with key still low → new key_press[0] at edge 13 after deassertion.
